fir_coeff_bank_ctrl: RTL and testbench

Sequences delivery of a newly designed coefficient set from the Parks-McClellan design engine's coefficient store into the running FIR filter's ping-pong coefficient banks. It reads the new taps over a one-cycle-latency read port and writes them, zero-padded to full length, into the inactive (shadow) bank. It then swaps banks on the next sample boundary so the filter never sees a partially updated set. It sits between the design engine output and the FIR tap memory.

---
 rtl/fir_coeff_bank_ctrl_if.sv | 29 ++
 rtl/fir_coeff_bank_ctrl.sv | 74 +++++++
 tb/tb_fir_coeff_bank_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_bank_ctrl_if.sv
// fir_coeff_bank_ctrl_if: engine-store read port, shadow-bank write port and bank-swap status
interface fir_coeff_bank_ctrl_if #(
    parameter int COEFF_W = 16,
    parameter int ADDR_W = 7
);
    logic start;
    logic [ADDR_W:0] numtaps;
    logic src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic signed [COEFF_W-1:0] src_data;
    logic wr_en;
    logic wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic signed [COEFF_W-1:0] wr_data;
    logic sample_strobe;
    logic active_bank;
    logic [ADDR_W:0] active_taps;
    logic busy;
    logic done;
    logic err;
    modport master (
        output start, numtaps, src_data, sample_strobe,
        input src_rd, src_addr, wr_en, wr_bank, wr_addr, wr_data, active_bank, active_taps, busy, done, err
    );
    modport slave (
        input start, numtaps, src_data, sample_strobe,
        output src_rd, src_addr, wr_en, wr_bank, wr_addr, wr_data, active_bank, active_taps, busy, done, err
    );
endinterface

// File: rtl/fir_coeff_bank_ctrl.sv
// fir_coeff_bank_ctrl: copies a new tap set, zero-padded, into the shadow bank and swaps banks on a sample boundary
module fir_coeff_bank_ctrl #(
    parameter int COEFF_W = 16,
    parameter int MAX_TAPS = 101,
    parameter int ADDR_W = 7
) (
    input logic clk,
    input logic rst,
    fir_coeff_bank_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, WAIT_SWAP} state_t;
    localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(MAX_TAPS);
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MAX_TAPS - 1);
    state_t state_q;
    logic [ADDR_W-1:0] k_q, pk_q;
    logic [ADDR_W:0] pend_q, taps_q;
    logic pv_q, pz_q, bank_q, done_q, err_q, rd_ok;
    assign rd_ok = (state_q == LOAD) && ({1'b0, k_q} < pend_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q <= '0;
            pk_q <= '0;
            pend_q <= '0;
            taps_q <= '0;
            pv_q <= 1'b0;
            pz_q <= 1'b0;
            bank_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q <= 1'b0;
            // one-deep stage aligns each tap index with its read data
            pv_q <= state_q == LOAD;
            pk_q <= k_q;
            pz_q <= rd_ok;
            case (state_q)
                IDLE: if (bus.start) begin
                    if (bus.numtaps != '0 && bus.numtaps <= MAX_N) begin
                        pend_q <= bus.numtaps;
                        k_q <= '0;
                        state_q <= LOAD;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                LOAD: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == LAST_K) state_q <= DRAIN;
                end
                DRAIN: state_q <= WAIT_SWAP;
                WAIT_SWAP: if (bus.sample_strobe) begin
                    bank_q <= ~bank_q;
                    taps_q <= pend_q;
                    done_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.src_rd = rd_ok;
    assign bus.src_addr = state_q == LOAD ? k_q : '0;
    assign bus.wr_en = pv_q;
    assign bus.wr_bank = ~bank_q;
    assign bus.wr_addr = pv_q ? pk_q : '0;
    assign bus.wr_data = (pv_q && pz_q) ? bus.src_data : '0;
    assign bus.active_bank = bank_q;
    assign bus.active_taps = taps_q;
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// tb_fir_coeff_bank_ctrl: randomized loads checked against a bank-level model of the expected shadow writes and swaps
module tb_fir_coeff_bank_ctrl;
    localparam int MAXT = 101;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    fir_coeff_bank_ctrl_if #(.COEFF_W(16), .ADDR_W(7)) bus ();
    fir_coeff_bank_ctrl #(.COEFF_W(16), .MAX_TAPS(MAXT), .ADDR_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic signed [15:0] src_mem [0:127];
    logic m_active;
    int m_taps;
    int vec = 0;
    int miscmp = 0;
    int rd_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    logic wq_bank [$];
    int wq_addr [$];
    logic signed [15:0] wq_data [$];
    // coefficient store with one-cycle read latency; garbage when not read
    always @(posedge clk) bus.src_data <= bus.src_rd ? src_mem[bus.src_addr] : 16'($urandom);
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq_bank.push_back(bus.wr_bank);
            wq_addr.push_back(int'(bus.wr_addr));
            wq_data.push_back(bus.wr_data);
        end
        if (bus.src_rd === 1'b1) rd_cnt++;
        if (bus.err === 1'b1) err_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        vec++;
        if ({bus.busy, bus.done, bus.err, bus.src_rd, bus.wr_en, bus.active_bank} !== 6'b0 || bus.active_taps !== 8'd0) begin
            miscmp++;
            $display("FAIL reset_ctrl: busy=%b done=%b err=%b src_rd=%b wr_en=%b bank=%b taps=%0d, need all 0", bus.busy, bus.done, bus.err, bus.src_rd, bus.wr_en, bus.active_bank, bus.active_taps);
        end
        vec++;
        if (bus.src_addr !== 7'd0 || bus.wr_addr !== 7'd0 || bus.wr_data !== 16'sd0) begin
            miscmp++;
            $display("FAIL reset_bus: src_addr=%0d wr_addr=%0d wr_data=%0d, need 0 0 0", bus.src_addr, bus.wr_addr, bus.wr_data);
        end
    endtask
    task automatic test_load(input int n, input int extra, input bit hold, input bit spam);
        logic exp_bank;
        logic signed [15:0] exp_d;
        int rd0, err0, done0, wq0;
        exp_bank = ~m_active;
        rd0 = rd_cnt; err0 = err_cnt; done0 = done_cnt; wq0 = wq_addr.size();
        bus.numtaps = 8'(n);
        bus.start = 1'b1;
        tick();
        bus.start = spam;
        if (spam) bus.numtaps = 8'd7;
        vec++;
        if (bus.busy !== 1'b1 || bus.src_rd !== 1'b1 || bus.src_addr !== 7'd0) begin
            miscmp++;
            $display("FAIL load_first: busy=%b src_rd=%b src_addr=%0d, need 1 1 0", bus.busy, bus.src_rd, bus.src_addr);
        end
        for (int c = 1; c < MAXT + 2; c++) begin
            bus.sample_strobe = hold || c == MAXT + 1 || $urandom_range(0, 3) == 0;
            if (c >= MAXT - 2) bus.start = 1'b0;
            tick();
            vec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                miscmp++;
                $display("FAIL load_busy c=%0d: done=%b busy=%b, need 0 1", c, bus.done, bus.busy);
            end
        end
        for (int c = 0; c < extra; c++) begin
            bus.sample_strobe = 1'b0;
            tick();
            vec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                miscmp++;
                $display("FAIL wait_swap c=%0d: done=%b busy=%b, need 0 1", c, bus.done, bus.busy);
            end
        end
        bus.sample_strobe = 1'b1;
        tick();
        bus.sample_strobe = hold;
        vec++;
        if (bus.done !== 1'b1 || bus.active_bank !== exp_bank || bus.active_taps !== 8'(n) || bus.busy !== 1'b0) begin
            miscmp++;
            $display("FAIL swap: done=%b bank=%b taps=%0d busy=%b, need 1 %b %0d 0", bus.done, bus.active_bank, bus.active_taps, bus.busy, exp_bank, n);
        end
        tick();
        bus.sample_strobe = 1'b0;
        vec++;
        if (bus.done !== 1'b0 || bus.active_bank !== exp_bank) begin
            miscmp++;
            $display("FAIL swap_after: done=%b bank=%b, need 0 %b", bus.done, bus.active_bank, exp_bank);
        end
        vec++;
        if (rd_cnt - rd0 != n || err_cnt != err0 || done_cnt - done0 != 1 || wq_addr.size() - wq0 != MAXT) begin
            miscmp++;
            $display("FAIL load_counts: reads=%0d errs=%0d dones=%0d writes=%0d, need %0d 0 1 %0d", rd_cnt - rd0, err_cnt - err0, done_cnt - done0, wq_addr.size() - wq0, n, MAXT);
        end
        for (int i = 0; i < MAXT && wq0 + i < wq_addr.size(); i++) begin
            exp_d = i < n ? src_mem[i] : 16'sd0;
            vec++;
            if (wq_bank[wq0+i] !== exp_bank || wq_addr[wq0+i] != i || wq_data[wq0+i] !== exp_d) begin
                miscmp++;
                $display("FAIL write[%0d]: bank=%b addr=%0d data=%0d, need %b %0d %0d", i, wq_bank[wq0+i], wq_addr[wq0+i], wq_data[wq0+i], exp_bank, i, exp_d);
            end
        end
        m_active = exp_bank;
        m_taps = n;
    endtask
    task automatic test_reject();
        int bad [3];
        int rd0, wq0, err0;
        bad[0] = 0; bad[1] = 102; bad[2] = $urandom_range(103, 255);
        rd0 = rd_cnt; wq0 = wq_addr.size(); err0 = err_cnt;
        foreach (bad[j]) begin
            bus.numtaps = 8'(bad[j]);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            vec++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
                miscmp++;
                $display("FAIL reject n=%0d: err=%b busy=%b, need 1 0", bad[j], bus.err, bus.busy);
            end
            tick();
            vec++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                miscmp++;
                $display("FAIL reject_after n=%0d: err=%b busy=%b, need 0 0", bad[j], bus.err, bus.busy);
            end
        end
        repeat (4) tick();
        vec++;
        if (rd_cnt != rd0 || wq_addr.size() != wq0 || err_cnt - err0 != 3 || bus.active_bank !== m_active || bus.active_taps !== 8'(m_taps)) begin
            miscmp++;
            $display("FAIL reject_side: reads=%0d writes=%0d errs=%0d bank=%b taps=%0d, need 0 0 3 %b %0d", rd_cnt - rd0, wq_addr.size() - wq0, err_cnt - err0, bus.active_bank, bus.active_taps, m_active, m_taps);
        end
    endtask
    task automatic test_mid_reset();
        bus.numtaps = 8'($urandom_range(60, MAXT));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (50) tick();
        vec++;
        if (bus.src_addr !== 7'd50 || bus.busy !== 1'b1) begin
            miscmp++;
            $display("FAIL mid_tap: src_addr=%0d busy=%b, need 50 1", bus.src_addr, bus.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++;
        if ({bus.busy, bus.active_bank, bus.wr_en, bus.src_rd, bus.done} !== 5'b0 || bus.active_taps !== 8'd0) begin
            miscmp++;
            $display("FAIL mid_reset: busy=%b bank=%b wr_en=%b src_rd=%b done=%b taps=%0d, need all 0", bus.busy, bus.active_bank, bus.wr_en, bus.src_rd, bus.done, bus.active_taps);
        end
        m_active = 1'b0;
        m_taps = 0;
        for (int i = 0; i < MAXT; i++) src_mem[i] = 16'($urandom);
        test_load(3, $urandom_range(0, 5), 1'b0, 1'b0);
    endtask
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.numtaps = '0;
        bus.sample_strobe = 1'b0;
        m_active = 1'b0;
        m_taps = 0;
        for (int i = 0; i < 128; i++) src_mem[i] = 16'($urandom);
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        src_mem[0] = 16'sd1; src_mem[1] = -16'sd2; src_mem[2] = 16'sd3; src_mem[3] = -16'sd4; src_mem[4] = 16'sd5;
        test_load(5, 7, 1'b0, 1'b0);
        for (int i = 0; i < MAXT; i++) src_mem[i] = 16'(i);
        test_load(MAXT, 0, 1'b1, 1'b0);
        test_reject();
        for (int i = 0; i < MAXT; i++) src_mem[i] = 16'($urandom);
        test_load($urandom_range(20, 90), 2, 1'b0, 1'b1);
        test_load($urandom_range(1, MAXT), 19, 1'b0, 1'b0);
        for (int i = 0; i < MAXT; i++) src_mem[i] = 16'($urandom);
        test_load($urandom_range(1, MAXT), $urandom_range(0, 10), 1'b0, 1'b0);
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
